// File: rtl/dac_capture_pkg.sv
// dac_capture_pkg: shared types and constants for the DAC bus capture block.
//   sample_t : one captured DAC write, {ch, data}
//   CH_A/CH_B: channel encodings carried on the dacab pin
`timescale 1ns/1ps
package dac_capture_pkg;

   localparam int unsigned DATA_W = 8;

   localparam logic CH_A = 1'b0;
   localparam logic CH_B = 1'b1;

   typedef struct packed {
      logic              ch;
      logic [DATA_W-1:0] data;
   } sample_t;

endpackage

// File: rtl/dac_capture_if.sv
// dac_capture_if: DAC parallel bus plus the sample readout stream.
//   dac_cs, dac_wr  : active-low chip select / write strobe (async to clk)
//   dacab, dac_data : channel select and data bus
//   out_valid/out_ready/out_data : FWFT sample stream out of the capture FIFO
// master = bus driver / stream consumer, slave = capture block.
`timescale 1ns/1ps
interface dac_capture_if;
   import dac_capture_pkg::*;

   logic              dac_cs;
   logic              dac_wr;
   logic              dacab;
   logic [DATA_W-1:0] dac_data;
   logic              out_valid;
   logic              out_ready;
   sample_t           out_data;

   modport master (
      output dac_cs, dac_wr, dacab, dac_data, out_ready,
      input  out_valid, out_data
   );

   modport slave (
      input  dac_cs, dac_wr, dacab, dac_data, out_ready,
      output out_valid, out_data
   );

endinterface

// File: rtl/dac_capture_fifo.sv
// dac_capture_fifo: synchronous first-word-fall-through sample FIFO.
//   clk, rst_n : clock, async active-low reset
//   clear      : synchronous flush (wins over push)
//   push/wdata : write request; dropped when full unless a pop happens the same cycle
//   pop        : consume head; ignored when empty
//   rdata      : head entry (zero when empty)
//   full/empty : occupancy flags derived from a separate count register
`timescale 1ns/1ps
module dac_capture_fifo
   import dac_capture_pkg::*;
#(
   parameter int unsigned DEPTH = 16
) (
   input  logic    clk,
   input  logic    rst_n,
   input  logic    clear,
   input  logic    push,
   input  sample_t wdata,
   input  logic    pop,
   output sample_t rdata,
   output logic    full,
   output logic    empty
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   sample_t            mem [DEPTH];
   logic [PTR_W-1:0]   wr_ptr, rd_ptr;
   logic [CNT_W-1:0]   count;
   logic               do_push, do_pop;

   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);
   assign do_pop  = pop & ~empty;
   // A pop in the same cycle frees the slot, so a full FIFO still accepts.
   assign do_push = push & (~full | pop);
   assign rdata   = empty ? '0 : mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push && !clear) mem[wr_ptr] <= wdata;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         unique case ({do_push, do_pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/dac_capture.sv
// dac_capture: receive side of the dual-channel 8-bit parallel DAC bus.
//   clk, rst_n   : clock, async active-low reset
//   bus          : dac_capture_if.slave (DAC pins in, FWFT sample stream out)
//   clear        : sync flush of FIFO, overflow, period and stats state
//   ch_a_val/ch_b_val : last captured value per channel
//   period_a/period_valid : clk cycles between channel-A upward MID_LEVEL crossings
//   overflow     : sticky, a sample was dropped on a full FIFO
//   min_a/max_a  : channel-A extremes when DAC_CAPTURE_STATS_EN is defined,
//                  otherwise tied to 8'h00 / 8'hFF
`timescale 1ns/1ps
module dac_capture
   import dac_capture_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH  = 16,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned PERIOD_W    = 24,
   parameter int unsigned MID_LEVEL   = 128
) (
   input  logic                clk,
   input  logic                rst_n,
   dac_capture_if.slave        bus,
   input  logic                clear,
   output logic [DATA_W-1:0]   ch_a_val,
   output logic [DATA_W-1:0]   ch_b_val,
   output logic [PERIOD_W-1:0] period_a,
   output logic                period_valid,
   output logic                overflow,
   output logic [DATA_W-1:0]   min_a,
   output logic [DATA_W-1:0]   max_a
);

   // Synchronized bus word layout: {cs, wr, ab, data}
   localparam int unsigned BUS_W = DATA_W + 3;
   localparam int unsigned CS_B  = DATA_W + 2;
   localparam int unsigned WR_B  = DATA_W + 1;
   localparam int unsigned AB_B  = DATA_W;
   // Strobes idle high so reset never looks like a write edge.
   localparam logic [BUS_W-1:0]  BUS_IDLE = {2'b11, 1'b0, {DATA_W{1'b0}}};
   localparam logic [DATA_W-1:0] MID      = DATA_W'(MID_LEVEL);

   logic [BUS_W-1:0]    sync_q [SYNC_STAGES];
   logic [BUS_W-1:0]    bus_s, bus_prev;
   logic                capture, push, full, empty;
   sample_t             sample;
   logic [PERIOD_W-1:0] cnt;
   logic                armed;
   logic [DATA_W-1:0]   prev_a;

   // All four inputs share one synchronizer chain so they stay cycle-aligned.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= BUS_IDLE;
         bus_prev <= BUS_IDLE;
      end else begin
         sync_q[0] <= {bus.dac_cs, bus.dac_wr, bus.dacab, bus.dac_data};
         for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
         bus_prev <= bus_s;
      end
   end

   assign bus_s   = sync_q[SYNC_STAGES-1];
   // WR rising edge with CS low in the previous cycle; sample from that cycle.
   assign capture = bus_s[WR_B] & ~bus_prev[WR_B] & ~bus_prev[CS_B];
   assign sample  = '{ch: bus_prev[AB_B], data: bus_prev[DATA_W-1:0]};
   assign push    = capture & ~clear;

   dac_capture_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .clear (clear),
      .push  (push),
      .wdata (sample),
      .pop   (bus.out_ready),
      .rdata (bus.out_data),
      .full  (full),
      .empty (empty)
   );

   assign bus.out_valid = ~empty;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ch_a_val     <= '0;
         ch_b_val     <= '0;
         overflow     <= 1'b0;
         cnt          <= '0;
         armed        <= 1'b0;
         prev_a       <= '1;
         period_a     <= '0;
         period_valid <= 1'b0;
      end else begin
         period_valid <= 1'b0;
         if (clear) begin
            overflow <= 1'b0;
            cnt      <= '0;
            armed    <= 1'b0;
            prev_a   <= '1;
            period_a <= '0;
         end else begin
            // Full implies non-empty, so out_ready alone means a pop frees a slot.
            if (push && full && !bus.out_ready) overflow <= 1'b1;
            if (cnt != '1) cnt <= cnt + PERIOD_W'(1);
            if (push && sample.ch == CH_B) ch_b_val <= sample.data;
            if (push && sample.ch == CH_A) begin
               ch_a_val <= sample.data;
               prev_a   <= sample.data;
               if (prev_a < MID && sample.data >= MID) begin
                  cnt   <= PERIOD_W'(1);
                  armed <= 1'b1;
                  if (armed) begin
                     period_a     <= cnt;
                     period_valid <= 1'b1;
                  end
               end
            end
         end
      end
   end

`ifdef DAC_CAPTURE_STATS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         min_a <= '1;
         max_a <= '0;
      end else if (clear) begin
         min_a <= '1;
         max_a <= '0;
      end else if (push && sample.ch == CH_A) begin
         if (sample.data < min_a) min_a <= sample.data;
         if (sample.data > max_a) max_a <= sample.data;
      end
   end
`else
   assign min_a = 8'h00;
   assign max_a = 8'hFF;
`endif

endmodule
